// File: rtl/timer_access_sequencer.sv
// timer_access_sequencer
//
// Turns 64-bit requests from the core into sequences of 32-bit accesses on
// the machine timer's memory-mapped bus (mtime / mtimecmp).
//
// Reads use hi/lo/hi with retry. The high word is read before and after the
// low word. If the two high words differ, the low word may have wrapped
// between the reads, so the whole pass is repeated. After MAX_RETRIES extra
// passes the last sample is returned with rsp_error set.
//
// Writes use a three-step sequence: LO <= safe value, HI <= new hi,
// LO <= new lo. For mtimecmp the safe value is all-ones, so the comparator
// never sees a half-written value that is smaller than mtime. For mtime the
// safe value is zero.
//
// Ports
//   clock, reset              rising-edge clock; asynchronous active-low reset
//   req_valid/req_ready       core request handshake (see below)
//   req_write, req_target     1 = write / 0 = read; 0 = mtime / 1 = mtimecmp
//   req_wdata                 64-bit write data
//   rsp_valid                 one-cycle completion pulse, no backpressure
//   rsp_rdata, rsp_error      read result and retry-exhaustion flag
//   readEnable, writeEnable   timer bus strobes, at most one per cycle
//   writeByteEnable           4'b1111 during any access, else 0
//   address, writeData        timer word address and write data
//   readData                  timer read data, valid the cycle after readEnable
//   dbg_state                 current sequencer state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE and only while reset is
// released. All request fields are captured on that edge, and req_valid is
// ignored until the sequencer is back in IDLE. rsp_valid is high for exactly
// one cycle per accepted request and cannot be stalled.

module timer_access_sequencer #(
    parameter int unsigned              DATA_WIDTH      = 32,
    parameter int unsigned              ADDRESS_BITS    = 32,
    parameter logic [ADDRESS_BITS-1:0]  MTIME_ADDR      = 32'h0020bff8,
    parameter logic [ADDRESS_BITS-1:0]  MTIME_ADDR_H    = 32'h0020bffc,
    parameter logic [ADDRESS_BITS-1:0]  MTIMECMP_ADDR   = 32'h00204000,
    parameter logic [ADDRESS_BITS-1:0]  MTIMECMP_ADDR_H = 32'h00204004,
    parameter int unsigned              MAX_RETRIES     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_target,
    input  logic [63:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [63:0]             rsp_rdata,
    output logic                    rsp_error,
    output logic                    readEnable,
    output logic                    writeEnable,
    output logic [3:0]              writeByteEnable,
    output logic [ADDRESS_BITS-1:0] address,
    output logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH-1:0]   readData,
    output logic [3:0]              dbg_state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RH1  = 4'd1,
        RL   = 4'd2,
        RH2  = 4'd3,
        CHK  = 4'd4,
        W1   = 4'd5,
        W2   = 4'd6,
        W3   = 4'd7,
        RESP = 4'd8
    } state_t;

    localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_t                 state_q,  state_d;
    logic [RETRY_W-1:0]     retry_q,  retry_d;
    logic                   write_q,  write_d;
    logic                   target_q, target_d;
    logic [63:0]            wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0]  hi1_q,    hi1_d;
    logic [DATA_WIDTH-1:0]  lo_q,     lo_d;
    logic [63:0]            rdata_q,  rdata_d;
    logic                   err_q,    err_d;

    logic [ADDRESS_BITS-1:0] addr_hi;
    logic [ADDRESS_BITS-1:0] addr_lo;

    // Word addresses of the selected 64-bit register.
    assign addr_hi = target_q ? MTIMECMP_ADDR_H : MTIME_ADDR_H;
    assign addr_lo = target_q ? MTIMECMP_ADDR   : MTIME_ADDR;

    // Gating with reset keeps req_ready low during reset even though the
    // state register already reads IDLE.
    assign req_ready = (state_q == IDLE) && reset;
    assign dbg_state = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            retry_q  <= '0;
            write_q  <= 1'b0;
            target_q <= 1'b0;
            wdata_q  <= '0;
            hi1_q    <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            retry_q  <= retry_d;
            write_q  <= write_d;
            target_q <= target_d;
            wdata_q  <= wdata_d;
            hi1_q    <= hi1_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        retry_d         = retry_q;
        write_d         = write_q;
        target_d        = target_q;
        wdata_d         = wdata_q;
        hi1_d           = hi1_q;
        lo_d            = lo_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        readEnable      = 1'b0;
        writeEnable     = 1'b0;
        address         = '0;
        writeData       = '0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_error       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    target_d = req_target;
                    wdata_d  = req_wdata;
                    retry_d  = '0;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = req_write ? W1 : RH1;
                end
            end
            RH1: begin
                readEnable = 1'b1;
                address    = addr_hi;
                state_d    = RL;
            end
            RL: begin
                // readData carries the high word requested in RH1.
                readEnable = 1'b1;
                address    = addr_lo;
                hi1_d      = readData;
                state_d    = RH2;
            end
            RH2: begin
                readEnable = 1'b1;
                address    = addr_hi;
                lo_d       = readData;
                state_d    = CHK;
            end
            CHK: begin
                // readData is the second high word. The sample is stored even
                // when it is torn, because an exhausted retry still reports it.
                rdata_d = {readData, lo_q};
                if (readData == hi1_q) begin
                    state_d = RESP;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = RH1;
                end else begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            W1: begin
                // Parks the low word at a safe value before the high word changes.
                writeEnable = 1'b1;
                address     = addr_lo;
                writeData   = target_q ? '1 : '0;
                state_d     = W2;
            end
            W2: begin
                writeEnable = 1'b1;
                address     = addr_hi;
                writeData   = wdata_q[63:32];
                state_d     = W3;
            end
            W3: begin
                writeEnable = 1'b1;
                address     = addr_lo;
                writeData   = wdata_q[31:0];
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = write_q ? 64'd0 : rdata_q;
                rsp_error = err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign writeByteEnable = (readEnable || writeEnable) ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_timer_access_sequencer.sv
module tb_timer_access_sequencer;

  localparam int          MAXR       = 2;
  localparam logic [31:0] MTIME_L    = 32'h0020bff8;
  localparam logic [31:0] MTIME_H    = 32'h0020bffc;
  localparam logic [31:0] MTIMECMP_L = 32'h00204000;
  localparam logic [31:0] MTIMECMP_H = 32'h00204004;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;   // index of the next rising edge

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_target = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        readEnable;
  logic        writeEnable;
  logic [3:0]  writeByteEnable;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData = '0;
  logic [3:0]  dbg_state;

  timer_access_sequencer #(
    .MAX_RETRIES(MAXR)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_target     (req_target),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .readEnable     (readEnable),
    .writeEnable    (writeEnable),
    .writeByteEnable(writeByteEnable),
    .address        (address),
    .writeData      (writeData),
    .readData       (readData),
    .dbg_state      (dbg_state)
  );

  // ---------------- timer bus model ----------------
  // A real mtime/mtimecmp pair, optionally overridden by a scripted list of
  // read values (consumed in bus order).
  logic [63:0] mtime_r    = '0;
  logic [63:0] mtimecmp_r = '1;
  logic [31:0] rd_script[$];
  logic [31:0] ret_q[$];
  bit          script_mode = 1'b0;
  int          irq_cnt = 0;

  function automatic logic [31:0] real_rd(input logic [31:0] a);
    case (a)
      MTIME_L:    return mtime_r[31:0];
      MTIME_H:    return mtime_r[63:32];
      MTIMECMP_L: return mtimecmp_r[31:0];
      MTIMECMP_H: return mtimecmp_r[63:32];
      default:    return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    logic [31:0] v;
    mtime_r <= mtime_r + 64'd1;
    if (mtime_r >= mtimecmp_r) irq_cnt <= irq_cnt + 1;
    if (writeEnable) begin
      case (address)
        MTIME_L:    mtime_r[31:0]     <= writeData;
        MTIME_H:    mtime_r[63:32]    <= writeData;
        MTIMECMP_L: mtimecmp_r[31:0]  <= writeData;
        MTIMECMP_H: mtimecmp_r[63:32] <= writeData;
        default: ;
      endcase
    end
    if (readEnable) begin
      if (script_mode && rd_script.size() > 0) v = rd_script.pop_front();
      else v = real_rd(address);
      readData <= v;
      ret_q.push_back(v);
    end
  end

  // ---------------- monitor ----------------
  // Entries carry the index of the edge at which the value is sampled.
  logic [80:0] obs_q[$];
  logic [80:0] rsp_obs_q[$];
  logic [80:0] exp_q[$];
  int          bus_bad = 0;

  always @(negedge clock) begin
    if (readEnable || writeEnable)
      obs_q.push_back({cyc[15:0], writeEnable, address, writeData});
    if (rsp_valid)
      rsp_obs_q.push_back({cyc[15:0], rsp_error, rsp_rdata});
    if (readEnable && writeEnable) bus_bad++;
    if ((readEnable || writeEnable) && writeByteEnable != 4'hF) bus_bad++;
    if (!(readEnable || writeEnable) && (address != 0 || writeData != 0 || writeByteEnable != 0))
      bus_bad++;
    if (!rsp_valid && (rsp_rdata != 0 || rsp_error)) bus_bad++;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [80:0] acc(input int c, input bit we, input logic [31:0] a,
                                      input logic [31:0] d);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, we, a, d};
  endfunction

  function automatic logic [80:0] rsp(input int c, input bit err, input logic [63:0] d);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, err, d};
  endfunction

  // ---------------- driver + reference model ----------------
  // Called and returns 1 time unit after a rising edge.
  task automatic run_txn(input bit wr, input bit tgt, input logic [63:0] wd,
                         input bit use_script, input bit hold,
                         input logic [63:0] real_exp, input bit lo_from_bus);
    logic [31:0] sc[$];
    logic [80:0] exp_rsp;
    logic [31:0] ha, la, h1, l, h2;
    int t, w;
    bit done;
    check("quiet_between", 96'(obs_q.size() + rsp_obs_q.size()), 96'd0);
    sc = rd_script;
    script_mode = use_script;
    exp_q.delete();
    ret_q.delete();
    ha = tgt ? MTIMECMP_H : MTIME_H;
    la = tgt ? MTIMECMP_L : MTIME_L;

    req_valid = 1'b1; req_write = wr; req_target = tgt; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clock); #1; w++; end
    if (!req_ready) begin
      check("accept", {95'd0, req_ready}, 96'd1);
      req_valid = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
    // Scramble the request fields: they must have been captured at accept.
    req_write = 1'($urandom); req_target = 1'($urandom); req_wdata = {$urandom, $urandom};

    exp_rsp = '0;
    if (wr) begin
      exp_q.push_back(acc(t + 1, 1'b1, la, tgt ? 32'hFFFF_FFFF : 32'h0));
      exp_q.push_back(acc(t + 2, 1'b1, ha, wd[63:32]));
      exp_q.push_back(acc(t + 3, 1'b1, la, wd[31:0]));
      exp_rsp = rsp(t + 4, 1'b0, 64'd0);
    end else if (use_script) begin
      done = 1'b0;
      for (int p = 0; p <= MAXR && !done; p++) begin
        exp_q.push_back(acc(t + 1 + 4 * p, 1'b0, ha, 32'h0));
        exp_q.push_back(acc(t + 2 + 4 * p, 1'b0, la, 32'h0));
        exp_q.push_back(acc(t + 3 + 4 * p, 1'b0, ha, 32'h0));
        h1 = sc[3 * p]; l = sc[3 * p + 1]; h2 = sc[3 * p + 2];
        if (h1 == h2) begin
          exp_rsp = rsp(t + 5 + 4 * p, 1'b0, {h2, l});
          done = 1'b1;
        end else if (p == MAXR) begin
          exp_rsp = rsp(t + 5 + 4 * p, 1'b1, {h2, l});
          done = 1'b1;
        end
      end
    end else begin
      exp_q.push_back(acc(t + 1, 1'b0, ha, 32'h0));
      exp_q.push_back(acc(t + 2, 1'b0, la, 32'h0));
      exp_q.push_back(acc(t + 3, 1'b0, ha, 32'h0));
      exp_rsp = rsp(t + 5, 1'b0, real_exp);
    end

    w = 0;
    while (rsp_obs_q.size() == 0 && w < 80) begin
      @(posedge clock); #1; w++;
      if (hold && rsp_obs_q.size() == 0) check("busy_ready", {95'd0, req_ready}, 96'd0);
    end
    req_valid = 1'b0;

    if (lo_from_bus && ret_q.size() > 1) exp_rsp[31:0] = ret_q[1];
    check("acc_count", 96'(obs_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("bus_access", obs_q[i], exp_q[i]);
    check("rsp_count", 96'(rsp_obs_q.size()), 96'd1);
    if (rsp_obs_q.size() > 0) check("rsp", rsp_obs_q[0], exp_rsp);

    rd_script.delete();
    obs_q.delete();
    rsp_obs_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int irq0, t;
    bit wr, tgt;
    logic [63:0] wd;
    logic [31:0] h1;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {95'd0, req_ready}, 96'd0);
    check("rst_bus", {readEnable, writeEnable, writeByteEnable, address, writeData}, 96'd0);
    check("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 96'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("ready_after_rst", {95'd0, req_ready}, 96'd1);

    // Read mtime from the real timer: high word is still 0.
    run_txn(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1);

    // Write mtimecmp; the comparator must never fire on the way.
    irq0 = irq_cnt;
    run_txn(1'b1, 1'b1, 64'h0000_0001_0000_0020, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("no_irq", 96'(irq_cnt - irq0), 96'd0);
    run_txn(1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 64'h0000_0001_0000_0020, 1'b0);

    // Single retry: hi 0,1 then 1,1; lo 5 then 2.
    rd_script = '{32'h0, 32'h5, 32'h1, 32'h1, 32'h2, 32'h1};
    run_txn(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);

    // Exhaustion: hi increments on every read.
    rd_script = '{32'h0, 32'hA, 32'h1, 32'h2, 32'hB, 32'h3, 32'h4, 32'hC, 32'h5};
    run_txn(1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);

    // req_valid held high through a read.
    rd_script = '{32'h7, 32'h9, 32'h7};
    run_txn(1'b0, 1'b1, 64'd0, 1'b1, 1'b1, 64'd0, 1'b0);

    // Reset in the middle of a write.
    check("quiet_before_rst", 96'(obs_q.size() + rsp_obs_q.size()), 96'd0);
    req_valid = 1'b1; req_write = 1'b1; req_target = 1'b1; req_wdata = 64'h1234_5678_9abc_def0;
    check("rstw_ready", {95'd0, req_ready}, 96'd1);
    t = cyc;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("rstw_bus", {readEnable, writeEnable, writeByteEnable, address, writeData}, 96'd0);
    check("rstw_ready_low", {95'd0, req_ready}, 96'd0);
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("rstw_ready_after", {95'd0, req_ready}, 96'd1);
    repeat (3) begin @(posedge clock); #1; end
    check("rstw_acc_count", 96'(obs_q.size()), 96'd1);
    if (obs_q.size() > 0) check("rstw_w1", obs_q[0], acc(t + 1, 1'b1, MTIMECMP_L, 32'hFFFF_FFFF));
    check("rstw_no_rsp", 96'(rsp_obs_q.size()), 96'd0);
    obs_q.delete();
    rsp_obs_q.delete();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(0, 1));
      tgt = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      if (!wr) begin
        for (int p = 0; p <= MAXR; p++) begin
          h1 = $urandom_range(0, 3);
          rd_script.push_back(h1);
          rd_script.push_back($urandom);
          rd_script.push_back(($urandom_range(0, 1) == 1) ? h1 : 32'($urandom_range(0, 3)));
        end
      end
      run_txn(wr, tgt, wd, 1'b1, $urandom_range(0, 3) == 0, 64'd0, 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    repeat (3) begin @(posedge clock); #1; end
    check("tail_quiet", 96'(obs_q.size() + rsp_obs_q.size()), 96'd0);
    check("bus_rules", 96'(bus_bad), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
